// File: rtl/edge_row_scanner.sv
// edge_row_scanner
//   Horizontal-gradient edge finder on a grey pixel stream. For each of
//   NUM_ROWS programmable rows it records the x-positions of accepted edges
//   into a show-ahead FIFO read out over a valid/ready port.
//
// Ports
//   clk, reset_n         pixel clock, asynchronous active-low reset
//   sop                  start of frame pulse: latches row_sel/threshold,
//                        clears per-frame state and flushes the FIFO
//   in_valid, x, y, grey pixel stream
//   row_sel, threshold   row targets (row i at [i*COORD_W +: COORD_W]) and
//                        gradient threshold, sampled on sop
//   edge_pix             overlay: all-ones where the gradient exceeds threshold
//   out_valid/out_ready  FIFO head handshake; out_x/out_row carry the head
//   row_count            accepted edges per row (8 bits per row)
//   overflow             sticky: an accepted edge was dropped
module edge_row_scanner #(
    parameter int PIX_W      = 8,
    parameter int COORD_W    = 11,
    parameter int NUM_ROWS   = 2,
    parameter int TAP_DIST   = 2,
    parameter int MIN_GAP    = 3,
    parameter int X_MIN      = 31,
    parameter int X_MAX      = 609,
    parameter int MAX_EDGES  = 30,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sop,
    input  logic                          in_valid,
    input  logic [COORD_W-1:0]            x,
    input  logic [COORD_W-1:0]            y,
    input  logic [PIX_W-1:0]              grey,
    input  logic [NUM_ROWS*COORD_W-1:0]   row_sel,
    input  logic [PIX_W-1:0]              threshold,
    output logic [PIX_W-1:0]              edge_pix,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COORD_W-1:0]            out_x,
    output logic [$clog2(NUM_ROWS):0]     out_row,
    output logic [NUM_ROWS*8-1:0]         row_count,
    output logic                          overflow
);

    localparam int ROW_W = $clog2(NUM_ROWS) + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ROW_W + COORD_W;

    localparam logic [COORD_W-1:0]        X_MIN_C     = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0]        X_MAX_C     = COORD_W'(X_MAX);
    localparam logic signed [COORD_W+1:0] MIN_GAP_C   = (COORD_W+2)'(MIN_GAP);
    localparam logic [7:0]                MAX_EDGES_C = 8'(MAX_EDGES);

    // frame configuration
    logic [NUM_ROWS*COORD_W-1:0] row_sel_q, row_sel_d;
    logic [PIX_W-1:0]            thr_q, thr_d;

    // stage 1: grey delay line plus the coordinates of its newest sample
    logic [PIX_W-1:0]   dly_q [TAP_DIST+1];
    logic [PIX_W-1:0]   dly_d [TAP_DIST+1];
    logic               v1_q, v1_d;
    logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;

    // stage 2: gradient decision
    logic               v2_q, v2_d;
    logic               hit2_q, hit2_d;
    logic [COORD_W-1:0] x2_q, x2_d, y2_q, y2_d;

    // per-row scan state
    logic [COORD_W-1:0]  prev_q [NUM_ROWS];
    logic [COORD_W-1:0]  prev_d [NUM_ROWS];
    logic [NUM_ROWS-1:0] seen_q, seen_d;
    logic [7:0]          cnt_q [NUM_ROWS];
    logic [7:0]          cnt_d [NUM_ROWS];
    logic                ovf_q, ovf_d;

    // output FIFO; pointers carry one extra wrap bit
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
    logic [COORD_W-1:0] out_x_q, out_x_d;
    logic [ROW_W-1:0]   out_row_q, out_row_d;

    // combinational helpers
    logic signed [PIX_W:0]     diff, grad;
    logic                      hit_now;
    logic [NUM_ROWS-1:0]       row_hit;
    logic                      matched;
    logic [ROW_W-1:0]          row_idx;
    logic [COORD_W-1:0]        sel_prev;
    logic                      sel_seen;
    logic [7:0]                sel_cnt;
    logic signed [COORD_W+1:0] gap;
    logic                      in_window, considered, accept;
    logic                      fifo_empty, fifo_full, push, pop;
    logic [ENT_W-1:0]          push_data;
    logic [AW:0]               rd_nxt;

    assign diff    = $signed({1'b0, dly_q[0]}) - $signed({1'b0, dly_q[TAP_DIST]});
    assign grad    = diff[PIX_W] ? -diff : diff;
    assign hit_now = grad > $signed({1'b0, thr_q});

    // Lowest-index row wins when several targets share the same y.
    always_comb begin
        row_hit  = '0;
        matched  = 1'b0;
        row_idx  = '0;
        sel_prev = '0;
        sel_seen = 1'b0;
        sel_cnt  = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!matched && row_sel_q[i*COORD_W +: COORD_W] == y2_q) begin
                row_hit[i] = 1'b1;
                matched    = 1'b1;
                row_idx    = ROW_W'(i);
            end
        end
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (row_hit[i]) begin
                sel_prev = prev_q[i];
                sel_seen = seen_q[i];
                sel_cnt  = cnt_q[i];
            end
        end
    end

    assign in_window  = (x2_q >= X_MIN_C) && (x2_q <= X_MAX_C);
    assign considered = v2_q && hit2_q && matched && in_window;
    assign gap        = $signed({2'b00, x2_q}) - $signed({2'b00, sel_prev});
    assign accept     = !sel_seen || (gap >= MIN_GAP_C);

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign push_data  = {row_idx, x2_q};

    always_comb begin
        row_sel_d = row_sel_q;
        thr_d     = thr_q;
        dly_d     = dly_q;
        v1_d      = in_valid;
        x1_d      = x1_q;
        y1_d      = y1_q;
        v2_d      = v1_q;
        hit2_d    = hit2_q;
        x2_d      = x2_q;
        y2_d      = y2_q;
        prev_d    = prev_q;
        seen_d    = seen_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        out_x_d   = out_x_q;
        out_row_d = out_row_q;
        push      = 1'b0;
        rd_nxt    = rd_q;

        if (sop) begin
            row_sel_d = row_sel;
            thr_d     = threshold;
            for (int k = 0; k <= TAP_DIST; k++) dly_d[k] = '0;
            v1_d   = 1'b0;
            v2_d   = 1'b0;
            hit2_d = 1'b0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                prev_d[i] = '0;
                cnt_d[i]  = '0;
            end
            seen_d = '0;
            ovf_d  = 1'b0;
            wr_d   = '0;
            rd_d   = '0;
        end else begin
            if (in_valid) begin
                for (int k = TAP_DIST; k > 0; k--)
                    dly_d[k] = (x == '0) ? '0 : dly_q[k-1];
                dly_d[0] = grey;
                x1_d     = x;
                y1_d     = y;
            end

            // stage 2 only moves on real samples so hit/x/y stay aligned
            if (v1_q) begin
                hit2_d = hit_now;
                x2_d   = x1_q;
                y2_d   = y1_q;
            end

            if (considered) begin
                for (int i = 0; i < NUM_ROWS; i++) begin
                    if (row_hit[i]) begin
                        prev_d[i] = x2_q;
                        seen_d[i] = 1'b1;
                        if (accept) begin
                            if (sel_cnt == MAX_EDGES_C) begin
                                ovf_d = 1'b1;
                            end else begin
                                cnt_d[i] = sel_cnt + 8'd1;
                                // a FIFO-full drop still counts as accepted
                                if (fifo_full && !pop) ovf_d = 1'b1;
                                else                   push  = 1'b1;
                            end
                        end
                    end
                end
            end

            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            rd_nxt = rd_d;

            // Registered head: hold the last value when the FIFO goes empty.
            if (wr_q != rd_nxt) begin
                {out_row_d, out_x_d} = mem_q[rd_nxt[AW-1:0]];
            end else if (push) begin
                {out_row_d, out_x_d} = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_sel_q <= '0;
            thr_q     <= '0;
            for (int k = 0; k <= TAP_DIST; k++) dly_q[k] <= '0;
            v1_q      <= 1'b0;
            x1_q      <= '0;
            y1_q      <= '0;
            v2_q      <= 1'b0;
            hit2_q    <= 1'b0;
            x2_q      <= '0;
            y2_q      <= '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                prev_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            seen_q    <= '0;
            ovf_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            out_x_q   <= '0;
            out_row_q <= '0;
        end else begin
            row_sel_q <= row_sel_d;
            thr_q     <= thr_d;
            dly_q     <= dly_d;
            v1_q      <= v1_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            v2_q      <= v2_d;
            hit2_q    <= hit2_d;
            x2_q      <= x2_d;
            y2_q      <= y2_d;
            prev_q    <= prev_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            out_x_q   <= out_x_d;
            out_row_q <= out_row_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
        end else if (push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    assign edge_pix = hit2_q ? '1 : '0;
    assign out_x    = out_x_q;
    assign out_row  = out_row_q;
    assign overflow = ovf_q;

    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_cnt
        assign row_count[gi*8 +: 8] = cnt_q[gi];
    end

endmodule

// File: tb/tb_edge_row_scanner.sv
// tb_edge_row_scanner
//   Scoreboard bench for edge_row_scanner: a behavioural model predicts the
//   queued {row, x} entries while pixels are driven; the monitor compares
//   them against the FIFO head on every pop.
module tb_edge_row_scanner;

    localparam int TAP = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sop = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] px = '0;
    logic [10:0] py = '0;
    logic [7:0]  grey = '0;
    logic [21:0] row_sel = '0;
    logic [7:0]  threshold = '0;
    logic [7:0]  edge_pix;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_x;
    logic [1:0]  out_row;
    logic [15:0] row_count;
    logic        overflow;

    always #5 clk = ~clk;

    edge_row_scanner dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sop       (sop),
        .in_valid  (in_valid),
        .x         (px),
        .y         (py),
        .grey      (grey),
        .row_sel   (row_sel),
        .threshold (threshold),
        .edge_pix  (edge_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_row   (out_row),
        .row_count (row_count),
        .overflow  (overflow)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int g [640];
    int rs [2];
    int thr_m;
    int prev_m [2];
    bit seen_m [2];
    int cnt_m [2];
    bit ovf_m;
    bit pop_planned = 1'b0;
    int pops = 0;
    int epix = 0;
    bit epix_en = 1'b0;
    int e;

    task automatic chk(input string tag, input int got, input int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                chk("pop_underflow", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("pop_row", int'(out_row), e / 4096);
                chk("pop_x", int'(out_x), e % 4096);
            end
        end
        if (epix_en && edge_pix == 8'hFF) epix++;
    end

    task automatic model_clear(input int r0, input int r1, input int th);
        rs[0] = r0; rs[1] = r1; thr_m = th;
        for (int i = 0; i < 2; i++) begin
            prev_m[i] = 0; seen_m[i] = 1'b0; cnt_m[i] = 0;
        end
        ovf_m = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_pix(input int xx, input int yy);
        int gp, grad, row;
        bit acc;
        gp   = (xx >= TAP) ? g[xx-TAP] : 0;
        grad = g[xx] - gp;
        if (grad < 0) grad = -grad;
        row = -1;
        for (int i = 0; i < 2; i++) if (row < 0 && rs[i] == yy) row = i;
        if (grad > thr_m && row >= 0 && xx >= 31 && xx <= 609) begin
            acc = !seen_m[row] || (xx - prev_m[row] >= 3);
            prev_m[row] = xx;
            seen_m[row] = 1'b1;
            if (acc) begin
                if (cnt_m[row] == 30) begin
                    ovf_m = 1'b1;
                end else begin
                    cnt_m[row]++;
                    if (exp_q.size() >= 32 && !pop_planned) ovf_m = 1'b1;
                    else exp_q.push_back(row * 4096 + xx);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_g();
        for (int i = 0; i < 640; i++) g[i] = 0;
    endtask

    task automatic seg(input int a, input int b, input int v);
        for (int i = a; i < b; i++) g[i] = v;
    endtask

    task automatic blocks(input int n);
        clear_g();
        for (int k = 0; k < n; k++) seg(48 + 16*k, 56 + 16*k, 200);
    endtask

    task automatic run_row(input int yy, input int pulse_x, input int last_x);
        for (int xx = 0; xx <= last_x; xx++) begin
            tick();
            in_valid    = 1'b1;
            px          = 11'(xx);
            py          = 11'(yy);
            grey        = 8'(g[xx]);
            pop_planned = (xx == pulse_x);
            if (pulse_x >= 0) out_ready = (xx == pulse_x + 2);
            model_pix(xx, yy);
        end
        pop_planned = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
    endtask

    task automatic start_frame(input int r0, input int r1, input int th);
        tick();
        in_valid  = 1'b0;
        sop       = 1'b1;
        row_sel   = {11'(r1), 11'(r0)};
        threshold = 8'(th);
        model_clear(r0, r1, th);
        tick();
        sop = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        @(negedge clk);
        chk({tag, "_cnt0"}, int'(row_count[7:0]), cnt_m[0]);
        chk({tag, "_cnt1"}, int'(row_count[15:8]), cnt_m[1]);
        chk({tag, "_ovf"}, int'(overflow), int'(ovf_m));
    endtask

    task automatic drain(input string tag, input int n);
        pops = 0;
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 400 && (exp_q.size() != 0 || out_valid); c++) @(negedge clk);
        tick();
        out_ready = 1'b0;
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_pops"}, pops, n);
    endtask

    initial begin
        model_clear(0, 0, 0);
        clear_g();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(row_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_epix", int'(edge_pix), 0);
        chk("rst_outx", int'(out_x), 0);
        #1 reset_n = 1'b1;

        // single step on row 0
        start_frame(100, 200, 40);
        clear_g();
        seg(50, 640, 200);
        epix = 0;
        epix_en = 1'b1;
        run_row(100, -1, 639);
        idle(4);
        epix_en = 1'b0;
        chk("t1_epix", epix, 2);
        check_frame("t1");
        drain("t1", 1);

        // gap rejection: hits 60..63 and 70..71, only 60 and 70 kept
        start_frame(100, 200, 40);
        clear_g();
        seg(60, 62, 100);
        seg(62, 70, 200);
        run_row(100, -1, 639);
        idle(4);
        check_frame("t2");
        drain("t2", 2);

        // window: hits at 29/30 and 610/611 are outside
        start_frame(100, 200, 40);
        clear_g();
        seg(29, 610, 200);
        run_row(100, -1, 639);
        idle(4);
        run_row(200, -1, 639);
        idle(4);
        check_frame("t3a");
        drain("t3a", 0);
        // window edges 31 and 609 are inside
        start_frame(100, 200, 40);
        clear_g();
        seg(31, 609, 200);
        run_row(100, -1, 639);
        idle(4);
        check_frame("t3b");
        drain("t3b", 2);

        // backpressure: 20 + 20 accepted, FIFO keeps 32
        start_frame(100, 200, 40);
        blocks(10);
        run_row(100, -1, 639);
        idle(4);
        run_row(200, -1, 639);
        idle(4);
        check_frame("t4");
        drain("t4", 32);

        // per-row cap
        start_frame(100, 200, 40);
        blocks(18);
        run_row(100, -1, 639);
        idle(4);
        check_frame("t5");
        drain("t5", 30);

        // full FIFO with simultaneous push and pop
        start_frame(100, 200, 40);
        blocks(8);
        run_row(100, -1, 639);
        idle(4);
        run_row(200, -1, 639);
        idle(4);
        clear_g();
        seg(300, 640, 200);
        run_row(100, 300, 639);
        idle(4);
        check_frame("t6");
        drain("t6", 32);

        // sop with 5 entries queued and a push in flight
        start_frame(100, 200, 40);
        clear_g();
        seg(48, 56, 200);
        seg(64, 72, 200);
        seg(80, 640, 200);
        run_row(100, -1, 639);
        idle(4);
        check_frame("t7a");
        clear_g();
        seg(57, 640, 200);
        run_row(200, -1, 58);
        start_frame(300, 400, 40);
        @(negedge clk);
        chk("t7_valid", int'(out_valid), 0);
        chk("t7_count", int'(row_count), 0);
        chk("t7_ovf", int'(overflow), 0);
        clear_g();
        seg(50, 640, 200);
        run_row(100, -1, 639);
        idle(4);
        run_row(300, -1, 639);
        idle(4);
        check_frame("t7b");
        drain("t7b", 1);

        // asynchronous reset mid-frame
        start_frame(100, 200, 40);
        clear_g();
        seg(50, 640, 200);
        run_row(100, -1, 300);
        idle(4);
        #1 reset_n = 1'b0;
        model_clear(0, 0, 0);
        #2;
        chk("t8_valid", int'(out_valid), 0);
        chk("t8_count", int'(row_count), 0);
        chk("t8_epix", int'(edge_pix), 0);
        chk("t8_outx", int'(out_x), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_row(100, -1, 639);
        idle(4);
        check_frame("t8");
        drain("t8", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
